// File: rtl/alu_system_checker.sv
// Observation-side response checker for the ALUSystem datapath: compares each
// accepted output sample against a preloaded expected-vector memory and keeps run statistics.
module alu_system_checker #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [ADDR_W:0]   NumVectors,
   input  logic              ExpWrEn,
   input  logic [ADDR_W-1:0] ExpWrAddr,
   input  logic [44:0]       ExpWrData,
   input  logic              ObsValid,
   output logic              ObsReady,
   input  logic [7:0]        ObsALU,
   input  logic [3:0]        ObsFlags,
   input  logic [7:0]        ObsARFB,
   input  logic [7:0]        ObsMem,
   input  logic [15:0]       ObsIR,
   output logic              Busy,
   output logic              Done,
   output logic              Pass,
   output logic [15:0]       ErrorCount,
   output logic              FirstFailValid,
   output logic [ADDR_W-1:0] FirstFailIndex,
   output logic [4:0]        MismatchMask
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

   state_t              state, next_state;
   logic [44:0]         exp_mem [DEPTH];
   logic [ADDR_W-1:0]   index;
   logic [ADDR_W:0]     num_lat;
   logic [ADDR_W:0]     num_clamped;
   logic [44:0]         exp_word;
   logic                exp_check;
   logic [4:0]          field_mask;
   logic                xfer;
   logic                last_xfer;
   logic                start_ok;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign xfer        = ObsValid && (state == RUN);
   assign last_xfer   = (({1'b0, index} + (ADDR_W+1)'(1)) == num_lat);
   assign start_ok    = Start && (state != RUN);
   assign num_clamped = (NumVectors > DEPTH_W) ? DEPTH_W : NumVectors;

   // Combinational read of the current expected word and per-field compare.
   assign exp_word   = exp_mem[index];
   assign exp_check  = exp_word[44];
   assign field_mask = {exp_word[43:36] != ObsALU,
                        exp_word[35:32] != ObsFlags,
                        exp_word[31:24] != ObsARFB,
                        exp_word[23:16] != ObsMem,
                        exp_word[15:0]  != ObsIR};

   always_ff @(posedge Clock) begin
      if (!Reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: begin
            if (Start) next_state = (NumVectors == '0) ? DONE : RUN;
         end
         RUN: begin
            if (xfer && last_xfer) next_state = DONE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign ObsReady = (state == RUN);
   assign Busy     = (state == RUN);
   assign Done     = (state == DONE);
   assign Pass     = Done && (ErrorCount == 16'd0);

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         index          <= '0;
         num_lat        <= '0;
         ErrorCount     <= '0;
         FirstFailValid <= 1'b0;
         FirstFailIndex <= '0;
         MismatchMask   <= '0;
      end else if (start_ok) begin
         index          <= '0;
         num_lat        <= num_clamped;
         ErrorCount     <= '0;
         FirstFailValid <= 1'b0;
         FirstFailIndex <= '0;
         MismatchMask   <= '0;
      end else if (xfer) begin
         index        <= index + ADDR_W'(1);
         MismatchMask <= exp_check ? field_mask : 5'd0;
         if (exp_check && (field_mask != 5'd0)) begin
            ErrorCount <= sat_inc(ErrorCount);
            if (!FirstFailValid) begin
               FirstFailValid <= 1'b1;
               FirstFailIndex <= index;
            end
         end
      end
   end

   // Memory is loaded only outside a run so a read never collides with a write.
   always_ff @(posedge Clock) begin
      if (ExpWrEn && (state != RUN) && ({1'b0, ExpWrAddr} < DEPTH_W))
         exp_mem[ExpWrAddr] <= ExpWrData;
   end

endmodule

// File: tb/tb_alu_system_checker.sv
// Directed bench for alu_system_checker: hand-computed expectations checked with immediate assertions.
module tb_alu_system_checker;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        Start = 1'b0;
   logic [8:0]  NumVectors = '0;
   logic        ExpWrEn = 1'b0;
   logic [7:0]  ExpWrAddr = '0;
   logic [44:0] ExpWrData = '0;
   logic        ObsValid = 1'b0;
   logic        ObsReady;
   logic [7:0]  ObsALU = '0;
   logic [3:0]  ObsFlags = '0;
   logic [7:0]  ObsARFB = '0;
   logic [7:0]  ObsMem = '0;
   logic [15:0] ObsIR = '0;
   logic        Busy, Done, Pass, FirstFailValid;
   logic [15:0] ErrorCount;
   logic [7:0]  FirstFailIndex;
   logic [4:0]  MismatchMask;

   int checks = 0;
   int errors = 0;

   alu_system_checker #(.DEPTH(256), .ADDR_W(8)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .NumVectors(NumVectors),
      .ExpWrEn(ExpWrEn), .ExpWrAddr(ExpWrAddr), .ExpWrData(ExpWrData),
      .ObsValid(ObsValid), .ObsReady(ObsReady), .ObsALU(ObsALU), .ObsFlags(ObsFlags),
      .ObsARFB(ObsARFB), .ObsMem(ObsMem), .ObsIR(ObsIR), .Busy(Busy), .Done(Done),
      .Pass(Pass), .ErrorCount(ErrorCount), .FirstFailValid(FirstFailValid),
      .FirstFailIndex(FirstFailIndex), .MismatchMask(MismatchMask)
   );

   always #5 Clock = ~Clock;

   function automatic logic [44:0] mk(input logic c, input logic [7:0] alu, input logic [3:0] fl,
                                      input logic [7:0] arfb, input logic [7:0] mem, input logic [15:0] ir);
      return {c, alu, fl, arfb, mem, ir};
   endfunction

   logic [44:0] v0, v1, v2, v3;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [44:0] d);
      ExpWrEn = 1'b1; ExpWrAddr = a; ExpWrData = d;
      @(negedge Clock);
      ExpWrEn = 1'b0;
   endtask

   task automatic start(input logic [8:0] n);
      Start = 1'b1; NumVectors = n;
      @(negedge Clock);
      Start = 1'b0;
   endtask

   // Present one sample for one cycle; ObsValid stays high for back-to-back calls.
   task automatic send(input logic [44:0] w);
      ObsValid = 1'b1;
      {ObsALU, ObsFlags, ObsARFB, ObsMem, ObsIR} = w[43:0];
      @(negedge Clock);
   endtask

   task automatic idle(input int n);
      ObsValid = 1'b0;
      repeat (n) @(negedge Clock);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " ObsReady"}, 32'(ObsReady), 0);
      chk({tag, " Busy"}, 32'(Busy), 0);
      chk({tag, " Done"}, 32'(Done), 0);
      chk({tag, " Pass"}, 32'(Pass), 0);
      chk({tag, " ErrorCount"}, 32'(ErrorCount), 0);
      chk({tag, " FFValid"}, 32'(FirstFailValid), 0);
      chk({tag, " FFIndex"}, 32'(FirstFailIndex), 0);
      chk({tag, " Mask"}, 32'(MismatchMask), 0);
   endtask

   initial begin
      v0 = mk(1'b1, 8'h11, 4'b0000, 8'h20, 8'h55, 16'hA001);
      v1 = mk(1'b1, 8'h22, 4'b0010, 8'h21, 8'h66, 16'hA002);
      v2 = mk(1'b1, 8'h3C, 4'b0100, 8'h22, 8'h77, 16'hA003);
      v3 = mk(1'b1, 8'h44, 4'b0001, 8'h23, 8'h88, 16'h1234);

      repeat (2) @(negedge Clock);
      chk_reset_vals("reset");
      Reset = 1'b1;
      wr(8'd0, v0); wr(8'd1, v1); wr(8'd2, v2); wr(8'd3, v3);

      // All-match run
      start(9'd4);
      chk("run busy", 32'(Busy), 1);
      chk("run ready", 32'(ObsReady), 1);
      send(v0); send(v1); send(v2);
      chk("run not done early", 32'(Done), 0);
      send(v3);
      ObsValid = 1'b0;
      chk("run done", 32'(Done), 1);
      chk("run busy low", 32'(Busy), 0);
      chk("run ready low", 32'(ObsReady), 0);
      chk("run pass", 32'(Pass), 1);
      chk("run errcnt", 32'(ErrorCount), 0);
      chk("run ffvalid", 32'(FirstFailValid), 0);
      idle(2);
      chk("done held", 32'(Done), 1);

      // Single-field mismatch on vector 2
      start(9'd4);
      send(v0); send(v1);
      send({v2[44], 8'h3D, v2[35:0]});
      chk("single errcnt", 32'(ErrorCount), 1);
      chk("single ffindex", 32'(FirstFailIndex), 2);
      chk("single ffvalid", 32'(FirstFailValid), 1);
      chk("single mask", 32'(MismatchMask), 32'b10000);
      send(v3);
      ObsValid = 1'b0;
      chk("single mask clean", 32'(MismatchMask), 0);
      chk("single done", 32'(Done), 1);
      chk("single pass", 32'(Pass), 0);

      // Skip vector with mismatching data plus observation gaps
      wr(8'd1, {1'b0, v1[43:0]});
      start(9'd4);
      chk("skip errcnt cleared", 32'(ErrorCount), 0);
      send(v0);
      idle(3);
      chk("gap busy", 32'(Busy), 1);
      send({v1[44:44], v1[43:0] ^ 44'hFF_F_FF_FF_FFFF});
      chk("skip mask", 32'(MismatchMask), 0);
      chk("skip errcnt", 32'(ErrorCount), 0);
      send(v2);
      chk("gap no early done", 32'(Done), 0);
      send(v3);
      ObsValid = 1'b0;
      chk("skip done", 32'(Done), 1);
      chk("skip pass", 32'(Pass), 1);
      wr(8'd1, v1);

      // Multiple failures: flags on vector 0, IR on vector 3
      start(9'd4);
      send({v0[44:36], 4'b1000, v0[31:0]});
      chk("multi mask0", 32'(MismatchMask), 32'b01000);
      send(v1); send(v2);
      send({v3[44:16], 16'h1235});
      ObsValid = 1'b0;
      chk("multi mask3", 32'(MismatchMask), 32'b00001);
      chk("multi errcnt", 32'(ErrorCount), 2);
      chk("multi ffindex", 32'(FirstFailIndex), 0);
      chk("multi ffvalid", 32'(FirstFailValid), 1);
      chk("multi pass", 32'(Pass), 0);

      // Zero-length run
      start(9'd0);
      chk("zero done", 32'(Done), 1);
      chk("zero pass", 32'(Pass), 1);
      chk("zero busy", 32'(Busy), 0);
      chk("zero errcnt", 32'(ErrorCount), 0);

      // Start and memory write issued mid-run are both ignored
      start(9'd4);
      send(v0);
      ObsValid = 1'b0;
      Start = 1'b1; NumVectors = 9'd1;
      ExpWrEn = 1'b1; ExpWrAddr = 8'd2; ExpWrData = mk(1'b1, 8'hEE, 4'hF, 8'hEE, 8'hEE, 16'hEEEE);
      @(negedge Clock);
      Start = 1'b0; ExpWrEn = 1'b0;
      send(v1);
      chk("midstart ignored", 32'(Done), 0);
      send(v2); send(v3);
      ObsValid = 1'b0;
      chk("midrun done", 32'(Done), 1);
      chk("midrun errcnt", 32'(ErrorCount), 0);
      start(9'd4);
      send(v0); send(v1); send(v2); send(v3);
      ObsValid = 1'b0;
      chk("rerun pass", 32'(Pass), 1);
      chk("rerun errcnt", 32'(ErrorCount), 0);

      // Reset mid-run after two transfers, one of them failing
      start(9'd4);
      send({v0[44], 8'h00, v0[35:0]});
      send(v1);
      ObsValid = 1'b0;
      chk("prereset errcnt", 32'(ErrorCount), 1);
      Reset = 1'b0;
      @(negedge Clock);
      Reset = 1'b1;
      chk_reset_vals("midreset");
      start(9'd4);
      send(v0); send(v1); send(v2); send(v3);
      ObsValid = 1'b0;
      chk("post reset done", 32'(Done), 1);
      chk("post reset pass", 32'(Pass), 1);
      chk("post reset errcnt", 32'(ErrorCount), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_system_checker.md
# alu_system_checker

Hardware response checker sitting on the observation side of the ALUSystem datapath. It consumes one ALUSystem output sample per accepted handshake and compares it against a preloaded expected-vector memory. It keeps an error count, the index of the first failing vector, and a pass/fail verdict. Together with the control-word stimulus path it forms a closed, self-checking test loop with no simulator display dependency.

## Interface

Parameters:
- DEPTH, 256: number of expected-vector entries.
- ADDR_W, 8: index width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  single-cycle pulse that begins a check run.
- NumVectors  in  ADDR_W+1  number of vectors in the run; sampled on Start.
- ExpWrEn  in  1  expected-memory write enable.
- ExpWrAddr  in  ADDR_W  expected-memory write address.
- ExpWrData  in  45  expected word: {Check, ALU_Out[7:0], Flags[3:0], ARF_OutB[7:0], MemOut[7:0], IR_Out[15:0]}.
- ObsValid  in  1  observed sample valid.
- ObsReady  out  1  checker accepts a sample.
- ObsALU  in  8  observed ALU output.
- ObsFlags  in  4  observed flags, ordered {Z,C,N,O}.
- ObsARFB  in  8  observed ARF OutB (memory address).
- ObsMem  in  8  observed memory output.
- ObsIR  in  16  observed IR output.
- Busy  out  1  run in progress.
- Done  out  1  run finished; held until the next Start or Reset.
- Pass  out  1  valid when Done; 1 iff ErrorCount == 0.
- ErrorCount  out  16  mismatching vectors; saturates at 16'hFFFF.
- FirstFailValid  out  1  at least one mismatch seen this run.
- FirstFailIndex  out  ADDR_W  index of the first mismatching vector.
- MismatchMask  out  5  per-field mismatch of the last compared vector, ordered {ALU, Flags, ARFB, Mem, IR}.

## Operation

- FSM states: IDLE, RUN, DONE. Reset forces IDLE.
- **IDLE**:
  - Start with NumVectors == 0 goes to DONE with Pass = 1.
  - Start with NumVectors > 0 goes to RUN. It clears Index, ErrorCount, FirstFailValid, FirstFailIndex and MismatchMask, and latches NumVectors.
- **RUN**:
  - ObsReady = 1. A transfer occurs when ObsValid & ObsReady.
  - On each transfer, read Exp[Index] combinationally and compare the five fields.
  - If Check = 1 and any field differs, it is an error: ErrorCount += 1 (saturating). If FirstFailValid = 0, set FirstFailIndex = Index and FirstFailValid = 1.
  - If Check = 0, the vector is skipped: Index still advances, and MismatchMask is written 0.
  - Index increments on every transfer. The transfer at Index == latched NumVectors-1 moves the FSM to DONE.
- **DONE**:
  - Done = 1 and ObsReady = 0. Statistics are frozen.
  - Start restarts exactly as from IDLE.
- Start while in RUN is ignored.
- ExpWrEn is honoured only in IDLE and DONE; writes in RUN are dropped. Writes with ExpWrAddr >= DEPTH are dropped.
- NumVectors > DEPTH is clamped to DEPTH when latched.
- Reset mid-run returns to IDLE and clears all statistics. Expected-memory contents are not cleared.

## Timing

- Reset values: ObsReady 0, Busy 0, Done 0, Pass 0, ErrorCount 0, FirstFailValid 0, FirstFailIndex 0, MismatchMask 0.
- Start is registered. Busy and ObsReady rise the cycle after the Start edge, so the first transfer can occur one cycle after Start.
- One vector per cycle is sustained while ObsValid stays high.
- ErrorCount, FirstFail* and MismatchMask reflect a transfer on the edge that accepts it: visible in the following cycle.
- Completion timing:
  - The final transfer edge sets Done = 1 and Busy = 0.
  - Pass is valid in that same cycle.
  - ObsReady drops in that cycle.
- ObsValid while ObsReady = 0 is ignored. The observed data needs no hold.
- An expected-memory write and a read of the same address in the same cycle cannot occur, because writes are blocked in RUN.

## Test plan

- **All-match run.**
  - Stimulus: load 4 vectors, pulse Start with NumVectors=4, drive ObsValid for 4 consecutive cycles with matching data.
  - Required response: Done 5 cycles after Start, Pass=1, ErrorCount=0, FirstFailValid=0.
- **Single-field mismatch.**
  - Stimulus: vector 2 expects ALU=8'h3C, observed ALU=8'h3D.
  - Required response: ErrorCount=1, FirstFailIndex=2, MismatchMask=5'b10000 after that transfer, Pass=0.
- **Skip and gaps.**
  - Stimulus: vector 1 has Check=0 with mismatching data; ObsValid is deasserted for 3 cycles mid-run.
  - Required response: ErrorCount=0, Index does not advance during the gaps, Pass=1.
- **Multiple failures.**
  - Stimulus: vectors 0 and 3 fail (flags 4'b1000 vs 4'b0000, IR 16'h1234 vs 16'h1235).
  - Required response: ErrorCount=2, FirstFailIndex=0.
- **Degenerate and ignored inputs.**
  - NumVectors=0 -> Done the next cycle with Pass=1.
  - Start pulsed mid-run -> ignored.
  - ExpWrEn in RUN -> memory unchanged, verified on a rerun.
- **Reset mid-run.**
  - Stimulus: Reset=0 for one edge after 2 transfers with 1 error.
  - Required response: all outputs return to reset values. A fresh run then uses the intact expected memory.
